pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Measures a complementary PWM pair fed back from the gate-driver side of the bridge.
//  Reports four values per switching cycle: period, A high time, and both dead times.
//  Raises sticky faults on shoot-through (A and B high together) and on dead time below
//  a minimum, and flags loss of switching. Sits beside each bridge leg for
//  closed-loop checking and protection.
// PARAMETERS
//  bit_width      21    width of every measurement counter/output
//  min_deadtime   10    smallest legal dead time, clk cycles
//  timeout_cycles 4000  cycles with no accepted edge before timeout
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          synchronous active-low reset
//  pwmA_in        in   1          asynchronous PWM A feedback
//  pwmB_in        in   1          asynchronous PWM B feedback
//  clear_fault    in   1          clears sticky faults
//  period         out  bit_width  cycles between consecutive A rises
//  high_time      out  bit_width  cycles from A rise to A fall
//  dead_ab        out  bit_width  cycles from A fall to B rise
//  dead_ba        out  bit_width  cycles from B fall to A rise
//  meas_valid     out  1          1-cycle pulse, measurement outputs updated
//  fault_overlap  out  1          sticky, A and B seen high together
//  fault_deadtime out  1          sticky, dead_ab or dead_ba < min_deadtime
//  timeout        out  1          level, no edge for timeout_cycles
// BEHAVIOUR
//  - Reset: synchronous, active-low. All outputs, synchronizers, counters = 0; state IDLE.
//  - Each input passes through a 2-FF synchronizer. Edges are detected on synced values.
//    An output updates 3 clk after the pin edge; measured lengths are unaffected.
//  - seg_cnt: set to 1 on every accepted edge, else +1. per_cnt: set to 1 on accepted
//    A rise, else +1. Both saturate at 2^bit_width-1, with no wrap.
//  - FSM (expected edge order A rise, A fall, B rise, B fall):
//    IDLE    -> HIGH_A on A rise (first rise only arms; no valid)
//    HIGH_A  -> DEAD_AB on A fall; latch high_time_r = seg_cnt
//    DEAD_AB -> HIGH_B on B rise; latch dead_ab_r = seg_cnt
//    HIGH_B  -> DEAD_BA on B fall
//    DEAD_BA -> HIGH_A on A rise. In that cycle: period = per_cnt, dead_ba = seg_cnt,
//               high_time and dead_ab take the latched values; meas_valid = 1.
//  - Any edge out of order (e.g. B rise in HIGH_A, A rise in DEAD_AB) -> IDLE, no valid.
//  - Overlap: synced A and B both 1 in any cycle -> fault_overlap = 1, FSM -> IDLE.
//  - Dead-time check at latch: dead_ab or dead_ba < min_deadtime -> fault_deadtime = 1.
//    meas_valid still pulses with the measured values.
//  - Timeout: seg_cnt reaches timeout_cycles with no edge -> timeout = 1, FSM -> IDLE.
//    This covers 0% and 100% duty. timeout clears on the next A rise.
//    After timeout, two A rises are needed before the next meas_valid.
//  - clear_fault = 1 clears both sticky faults next cycle. If a fault condition occurs in
//    the same cycle, set wins.
//  - Measurement outputs hold their last values between meas_valid pulses.
//  - Reset mid-operation discards any partial cycle.
// TESTING
//  1. A high 150, dead 10, B high 230, dead 10, repeated -> each valid: period=400,
//     high_time=150, dead_ab=10, dead_ba=10. meas_valid every 400 clk; first A rise
//     gives no pulse.
//  2. Same as 1 but dead_ab = 5 -> fault_deadtime=1 and meas_valid with dead_ab=5. Pulse
//     clear_fault -> 0 on next cycle. Another violation in that cycle -> stays 1.
//  3. A and B both high 1 cycle during HIGH_B -> fault_overlap=1 within 3 clk, no valid
//     that cycle, valid resumes after two clean A rises.
//  4. Hold both inputs low 4000 clk -> timeout=1, no meas_valid. Restart switching:
//     timeout=0 at first A rise, valid at the second.
//  5. bit_width=8: A high 300 clk -> high_time=255 (saturated); period saturates at 255.
//  6. rst_n low 1 clk while in HIGH_B -> all outputs 0 next clk, no valid until a full
//     cycle after the next A rise.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: per-cycle period, high time and dead times of a complementary
// PWM pair, with sticky shoot-through / short dead-time faults and timeout.
module pwm_capture #(
  parameter int bit_width      = 21,
  parameter int min_deadtime   = 10,
  parameter int timeout_cycles = 4000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwmA_in,
  input  logic                 pwmB_in,
  input  logic                 clear_fault,
  output logic [bit_width-1:0] period,
  output logic [bit_width-1:0] high_time,
  output logic [bit_width-1:0] dead_ab,
  output logic [bit_width-1:0] dead_ba,
  output logic                 meas_valid,
  output logic                 fault_overlap,
  output logic                 fault_deadtime,
  output logic                 timeout
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HIGH_A  = 3'd1;
  localparam logic [2:0] DEAD_AB = 3'd2;
  localparam logic [2:0] HIGH_B  = 3'd3;
  localparam logic [2:0] DEAD_BA = 3'd4;

  localparam logic [bit_width-1:0] CNT_ONE = bit_width'(1);
  localparam logic [bit_width-1:0] CNT_MAX = '1;
  localparam logic [bit_width-1:0] MIN_DT  = bit_width'(min_deadtime);
  localparam logic [bit_width-1:0] TMO_VAL = bit_width'(timeout_cycles);
  // A timeout beyond the saturated counter range can never fire
  localparam bit TMO_ON = 64'(timeout_cycles) <= 64'(CNT_MAX);

  logic [2:0] a_sync_q, a_sync_d;
  logic [2:0] b_sync_q, b_sync_d;
  logic [2:0] state_q, state_d;
  logic [bit_width-1:0] seg_q, seg_d;
  logic [bit_width-1:0] per_q, per_d;
  logic [bit_width-1:0] hl_q, hl_d;
  logic [bit_width-1:0] dabl_q, dabl_d;
  logic [bit_width-1:0] period_q, period_d;
  logic [bit_width-1:0] high_q, high_d;
  logic [bit_width-1:0] dab_q, dab_d;
  logic [bit_width-1:0] dba_q, dba_d;
  logic valid_q, valid_d;
  logic fo_q, fo_d;
  logic fd_q, fd_d;
  logic tmo_q, tmo_d;

  logic a, a_prev, b, b_prev;
  logic a_rise, a_fall, b_rise, b_fall;
  logic any_edge, overlap, tmo_hit, dt_set;
  logic [3:0] edges;
  logic [bit_width-1:0] seg_inc, per_inc;

  assign a_sync_d = {a_sync_q[1:0], pwmA_in};
  assign b_sync_d = {b_sync_q[1:0], pwmB_in};

  assign a      = a_sync_q[1];
  assign a_prev = a_sync_q[2];
  assign b      = b_sync_q[1];
  assign b_prev = b_sync_q[2];

  assign a_rise   = a & ~a_prev;
  assign a_fall   = ~a & a_prev;
  assign b_rise   = b & ~b_prev;
  assign b_fall   = ~b & b_prev;
  assign edges    = {a_rise, a_fall, b_rise, b_fall};
  assign any_edge = |edges;
  assign overlap  = a & b;

  assign seg_inc = (seg_q == CNT_MAX) ? seg_q : seg_q + CNT_ONE;
  assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + CNT_ONE;
  assign tmo_hit = TMO_ON && (seg_q >= TMO_VAL);

  assign seg_d = any_edge ? CNT_ONE : seg_inc;
  assign per_d = a_rise ? CNT_ONE : per_inc;

  always_comb begin
    state_d  = state_q;
    hl_d     = hl_q;
    dabl_d   = dabl_q;
    period_d = period_q;
    high_d   = high_q;
    dab_d    = dab_q;
    dba_d    = dba_q;
    valid_d  = 1'b0;
    dt_set   = 1'b0;
    if (overlap) begin
      state_d = IDLE;
    end else if (any_edge) begin
      // Only the single expected edge advances; anything else disarms
      unique case (state_q)
        IDLE: begin
          if (a_rise) state_d = HIGH_A;
        end
        HIGH_A: begin
          if (edges == 4'b0100) begin
            state_d = DEAD_AB;
            hl_d    = seg_q;
          end else begin
            state_d = IDLE;
          end
        end
        DEAD_AB: begin
          if (edges == 4'b0010) begin
            state_d = HIGH_B;
            dabl_d  = seg_q;
            dt_set  = seg_q < MIN_DT;
          end else begin
            state_d = IDLE;
          end
        end
        HIGH_B: begin
          if (edges == 4'b0001) state_d = DEAD_BA;
          else                  state_d = IDLE;
        end
        DEAD_BA: begin
          if (edges == 4'b1000) begin
            state_d  = HIGH_A;
            period_d = per_q;
            high_d   = hl_q;
            dab_d    = dabl_q;
            dba_d    = seg_q;
            valid_d  = 1'b1;
            dt_set   = seg_q < MIN_DT;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    fo_d = overlap | (fo_q & ~clear_fault);
    fd_d = dt_set | (fd_q & ~clear_fault);
    if (a_rise)                    tmo_d = 1'b0;
    else if (!any_edge && tmo_hit) tmo_d = 1'b1;
    else                           tmo_d = tmo_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      state_q  <= IDLE;
      seg_q    <= '0;
      per_q    <= '0;
      hl_q     <= '0;
      dabl_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      dab_q    <= '0;
      dba_q    <= '0;
      valid_q  <= 1'b0;
      fo_q     <= 1'b0;
      fd_q     <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      state_q  <= state_d;
      seg_q    <= seg_d;
      per_q    <= per_d;
      hl_q     <= hl_d;
      dabl_q   <= dabl_d;
      period_q <= period_d;
      high_q   <= high_d;
      dab_q    <= dab_d;
      dba_q    <= dba_d;
      valid_q  <= valid_d;
      fo_q     <= fo_d;
      fd_q     <= fd_d;
      tmo_q    <= tmo_d;
    end
  end

  assign period         = period_q;
  assign high_time      = high_q;
  assign dead_ab        = dab_q;
  assign dead_ba        = dba_q;
  assign meas_valid     = valid_q;
  assign fault_overlap  = fo_q;
  assign fault_deadtime = fd_q;
  assign timeout        = tmo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: timestamp-based reference model compared every cycle
// against a 21-bit and an 8-bit instance, plus literal spot checks.
module tb_pwm_capture;

  localparam int MIN_DT = 10;
  localparam int TMO    = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pin_a = 1'b0;
  logic pin_b = 1'b0;
  logic clear = 1'b0;

  logic [20:0] p0, h0, da0, db0;
  logic        v0, fo0, fd0, t0;
  logic [7:0]  p1, h1, da1, db1;
  logic        v1, fo1, fd1, t1;

  always #5 clk = ~clk;

  pwm_capture u_dut (
    .clk(clk), .rst_n(rst_n),
    .pwmA_in(pin_a), .pwmB_in(pin_b),
    .clear_fault(clear),
    .period(p0), .high_time(h0),
    .dead_ab(da0), .dead_ba(db0),
    .meas_valid(v0),
    .fault_overlap(fo0),
    .fault_deadtime(fd0),
    .timeout(t0)
  );

  pwm_capture #(.bit_width(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .pwmA_in(pin_a), .pwmB_in(pin_b),
    .clear_fault(clear),
    .period(p1), .high_time(h1),
    .dead_ab(da1), .dead_ba(db1),
    .meas_valid(v1),
    .fault_overlap(fo1),
    .fault_deadtime(fd1),
    .timeout(t1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: cycle timestamps of the last edge / last A rise
  int  maxv[2] = '{2097151, 255};
  int  m_per[2], m_high[2], m_dab[2], m_dba[2];
  bit  m_valid[2], m_fo[2], m_fd[2], m_tmo[2];
  bit  armed[2];
  int  expct[2], hl[2], dabl[2];
  int  last_edge[2], last_rise[2];
  bit  ha[3], hb[3];
  int  ncyc = 0;
  bit  model_ok = 1'b0;

  function automatic int sat(input int x, input int m);
    return (x > m) ? m : x;
  endfunction

  always @(posedge clk) begin : model
    bit ya, yap, yb, ybp, ra, fa, rb, fb, edg, only, dset;
    int seg, per;
    ncyc++;
    if (!rst_n) begin
      ha = '{0, 0, 0};
      hb = '{0, 0, 0};
      for (int k = 0; k < 2; k++) begin
        m_per[k] = 0; m_high[k] = 0;
        m_dab[k] = 0; m_dba[k] = 0;
        m_valid[k] = 0; m_fo[k] = 0;
        m_fd[k] = 0; m_tmo[k] = 0;
        armed[k] = 0; expct[k] = 0;
        last_edge[k] = ncyc + 1;
        last_rise[k] = ncyc + 1;
      end
      model_ok = 1'b1;
    end else begin
      ya = ha[1]; yap = ha[2];
      yb = hb[1]; ybp = hb[2];
      ra = ya & !yap; fa = !ya & yap;
      rb = yb & !ybp; fb = !yb & ybp;
      edg  = ra | fa | rb | fb;
      only = (int'(ra) + int'(fa) + int'(rb) + int'(fb)) == 1;
      for (int k = 0; k < 2; k++) begin
        seg = sat(ncyc - last_edge[k], maxv[k]);
        per = sat(ncyc - last_rise[k], maxv[k]);
        m_valid[k] = 0;
        dset = 0;
        if (ya && yb) begin
          armed[k] = 0;
        end else if (edg) begin
          if (!armed[k]) begin
            if (ra) begin armed[k] = 1; expct[k] = 0; end
          end else if (only && expct[k] == 0 && fa) begin
            hl[k] = seg; expct[k] = 1;
          end else if (only && expct[k] == 1 && rb) begin
            dabl[k] = seg; dset = seg < MIN_DT; expct[k] = 2;
          end else if (only && expct[k] == 2 && fb) begin
            expct[k] = 3;
          end else if (only && expct[k] == 3 && ra) begin
            m_per[k] = per; m_high[k] = hl[k];
            m_dab[k] = dabl[k]; m_dba[k] = seg;
            m_valid[k] = 1; dset = seg < MIN_DT;
            expct[k] = 0;
          end else begin
            armed[k] = 0;
          end
        end else if (seg >= TMO) begin
          armed[k] = 0;
        end
        if (ra) m_tmo[k] = 0;
        else if (!edg && seg >= TMO) m_tmo[k] = 1;
        m_fo[k] = (ya && yb) || (m_fo[k] && !clear);
        m_fd[k] = dset || (m_fd[k] && !clear);
        if (edg) last_edge[k] = ncyc;
        if (ra) last_rise[k] = ncyc;
      end
      ha[2] = ha[1]; ha[1] = ha[0]; ha[0] = pin_a;
      hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = pin_b;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("d0.period", int'(p0), m_per[0]);
      chk("d0.high", int'(h0), m_high[0]);
      chk("d0.dead_ab", int'(da0), m_dab[0]);
      chk("d0.dead_ba", int'(db0), m_dba[0]);
      chk("d0.valid", int'(v0), int'(m_valid[0]));
      chk("d0.f_ovl", int'(fo0), int'(m_fo[0]));
      chk("d0.f_dt", int'(fd0), int'(m_fd[0]));
      chk("d0.timeout", int'(t0), int'(m_tmo[0]));
      chk("d8.period", int'(p1), m_per[1]);
      chk("d8.high", int'(h1), m_high[1]);
      chk("d8.dead_ab", int'(da1), m_dab[1]);
      chk("d8.dead_ba", int'(db1), m_dba[1]);
      chk("d8.valid", int'(v1), int'(m_valid[1]));
      chk("d8.f_ovl", int'(fo1), int'(m_fo[1]));
      chk("d8.f_dt", int'(fd1), int'(m_fd[1]));
      chk("d8.timeout", int'(t1), int'(m_tmo[1]));
    end
  end

  typedef struct {
    int p;
    int h;
    int a;
    int b;
  } meas_t;
  meas_t got_q[$];

  always @(negedge clk) begin
    if (v0) got_q.push_back('{int'(p0), int'(h0), int'(da0), int'(db0)});
  end

  task automatic hold(input bit a, input bit b, input int n,
                      input bit clr, input bit rst);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pin_a = a;
      pin_b = b;
      clear = clr;
      rst_n = !rst;
    end
  endtask

  task automatic pcyc(input int h, input int dab,
                      input int bh, input int dba);
    hold(1, 0, h, 0, 0);
    hold(0, 0, dab, 0, 0);
    hold(0, 1, bh, 0, 0);
    hold(0, 0, dba, 0, 0);
  endtask

  int exp_p[13] = '{400, 400, 400, 400, 400, 400, 400,
                    400, 400, 550, 400, 400, 400};
  int exp_h[13] = '{150, 150, 150, 150, 150, 150, 150,
                    150, 150, 300, 150, 150, 150};
  int exp_a[13] = '{10, 10, 10, 10, 5, 5, 10,
                    10, 10, 10, 10, 10, 10};

  initial begin
    hold(0, 0, 3, 0, 1);
    hold(0, 0, 1, 0, 0);
    chk("reset.period", int'(p0), 0);
    chk("reset.valid", int'(v0), 0);
    chk("reset.timeout", int'(t0), 0);

    // nominal 400-cycle switching
    repeat (4) pcyc(150, 10, 230, 10);

    // short dead_ab, clear, then set-wins-over-clear
    hold(1, 0, 150, 0, 0);
    hold(0, 0, 5, 0, 0);
    hold(0, 1, 20, 0, 0);
    chk("dt.set", int'(fd0), 1);
    hold(0, 1, 80, 0, 0);
    hold(0, 1, 1, 1, 0);
    hold(0, 1, 10, 0, 0);
    chk("dt.clear", int'(fd0), 0);
    hold(0, 1, 124, 0, 0);
    hold(0, 0, 10, 0, 0);
    hold(1, 0, 150, 0, 0);
    hold(0, 0, 5, 0, 0);
    hold(0, 1, 2, 0, 0);
    hold(0, 1, 1, 1, 0);
    hold(0, 1, 20, 0, 0);
    chk("dt.setwins", int'(fd0), 1);
    hold(0, 1, 212, 0, 0);
    hold(0, 0, 10, 0, 0);

    // one-cycle shoot-through during B high
    pcyc(150, 10, 230, 10);
    hold(1, 0, 150, 0, 0);
    hold(0, 0, 10, 0, 0);
    hold(0, 1, 100, 0, 0);
    hold(1, 1, 1, 0, 0);
    hold(0, 1, 10, 0, 0);
    chk("ovl.set", int'(fo0), 1);
    hold(0, 1, 119, 0, 0);
    hold(0, 0, 10, 0, 0);
    pcyc(150, 10, 230, 10);
    pcyc(150, 10, 230, 10);

    // loss of switching
    hold(0, 0, 4100, 0, 0);
    chk("tmo.set", int'(t0), 1);
    chk("tmo.d8", int'(t1), 0);
    hold(0, 0, 1, 1, 0);
    hold(0, 0, 2, 0, 0);
    chk("clr.ovl", int'(fo0), 0);
    chk("clr.dt", int'(fd0), 0);
    hold(1, 0, 20, 0, 0);
    chk("tmo.clear", int'(t0), 0);
    hold(1, 0, 130, 0, 0);
    hold(0, 0, 10, 0, 0);
    hold(0, 1, 230, 0, 0);
    hold(0, 0, 10, 0, 0);

    // long high time: 8-bit instance saturates
    pcyc(300, 10, 230, 10);
    hold(1, 0, 20, 0, 0);
    chk("sat.d8.high", int'(h1), 255);
    chk("sat.d8.period", int'(p1), 255);
    chk("sat.d8.dead_ab", int'(da1), 10);
    chk("sat.d0.high", int'(h0), 300);
    chk("sat.d0.period", int'(p0), 550);
    hold(1, 0, 130, 0, 0);
    hold(0, 0, 10, 0, 0);
    hold(0, 1, 230, 0, 0);
    hold(0, 0, 10, 0, 0);

    // reset pulse while B is high
    hold(1, 0, 150, 0, 0);
    hold(0, 0, 10, 0, 0);
    hold(0, 1, 100, 0, 0);
    hold(0, 1, 1, 0, 1);
    @(posedge clk);
    #1;
    chk("rst.period", int'(p0), 0);
    chk("rst.high", int'(h0), 0);
    chk("rst.dead_ab", int'(da0), 0);
    chk("rst.dead_ba", int'(db0), 0);
    hold(0, 1, 129, 0, 0);
    hold(0, 0, 10, 0, 0);
    pcyc(150, 10, 230, 10);
    pcyc(150, 10, 230, 10);
    hold(1, 0, 10, 0, 0);
    hold(0, 0, 20, 0, 0);

    chk("nvalid", got_q.size(), 13);
    for (int i = 0; i < 13 && i < got_q.size(); i++) begin
      chk($sformatf("v%0d.period", i), got_q[i].p, exp_p[i]);
      chk($sformatf("v%0d.high", i), got_q[i].h, exp_h[i]);
      chk($sformatf("v%0d.dead_ab", i), got_q[i].a, exp_a[i]);
      chk($sformatf("v%0d.dead_ba", i), got_q[i].b, 10);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
